// File: rtl/mem_stage_handoff.sv
// mem_stage_handoff: MEM-stage sending end of the MEM->WB valid/allowin handshake.
// Holds the bundle until the lane-1 data-SRAM response lands, buffers it across WB stalls, drops flushed responses.
module mem_stage_handoff #(
   parameter int DATA_W = 32,
   parameter int DISC_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line1_now_valid_i,
   input  logic              line2_now_valid_i,
   input  logic              line1_mem_wait_i,
   input  logic              excep_flush_i,
   input  logic              next_allowin_i,
   input  logic              data_sram_data_ok_i,
   input  logic [DATA_W-1:0] data_sram_rdata_i,
   output logic              now_allowin_o,
   output logic              line1_now_to_next_valid_o,
   output logic              line2_now_to_next_valid_o,
   output logic [DATA_W-1:0] load_data_o,
   output logic [DISC_W-1:0] discard_cnt_o
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam logic [DISC_W-1:0] DISC_MAX = '1;
   state_t state;
   logic [DATA_W-1:0] data_buf;
   logic [DISC_W-1:0] discard_cnt;
   logic bundle_valid, need, accept, drop, ready_go, inc;
   assign bundle_valid = line1_now_valid_i | line2_now_valid_i;
   assign need = line1_now_valid_i & line1_mem_wait_i;
   assign accept = data_sram_data_ok_i & (discard_cnt == '0);
   assign drop = data_sram_data_ok_i & (discard_cnt != '0);
   assign ready_go = !need | (state == DONE) | accept;
   // a flushed request whose response is still owed becomes a response to discard later
   assign inc = excep_flush_i & !accept & ((state == WAIT) | ((state == IDLE) & need));
   assign now_allowin_o = !bundle_valid | (ready_go & next_allowin_i);
   assign line1_now_to_next_valid_o = line1_now_valid_i & ready_go & !excep_flush_i;
   assign line2_now_to_next_valid_o = line2_now_valid_i & ready_go & !excep_flush_i;
   assign load_data_o = (state == DONE) ? data_buf : data_sram_rdata_i;
   assign discard_cnt_o = discard_cnt;
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= IDLE;
         data_buf <= '0;
         discard_cnt <= '0;
      end else begin
         if (inc & !drop & (discard_cnt != DISC_MAX)) discard_cnt <= discard_cnt + DISC_W'(1);
         else if (drop & !inc) discard_cnt <= discard_cnt - DISC_W'(1);
         if (excep_flush_i) state <= IDLE;
         else begin
            case (state)
               IDLE: begin
                  if (need & !accept) state <= WAIT;
                  else if (need & accept & !next_allowin_i) begin
                     state <= DONE;
                     data_buf <= data_sram_rdata_i;
                  end
               end
               WAIT: begin
                  if (accept & next_allowin_i) state <= IDLE;
                  else if (accept) begin
                     state <= DONE;
                     data_buf <= data_sram_rdata_i;
                  end
               end
               DONE: if (next_allowin_i) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_handoff.sv
// tb_mem_stage_handoff: directed scenarios plus randomized run against a behavioural model of the handoff.
module tb_mem_stage_handoff;
   logic clk = 0, rst_n = 0;
   logic l1 = 0, l2 = 0, mw = 0, flush = 0, nxt = 1, ok = 0;
   logic [31:0] rdata = 0;
   logic allowin, v1, v2;
   logic [31:0] load;
   logic [1:0] cnt;
   int tests = 0, fails = 0;
   // model: is a response owed, is one parked for a stalled WB, and how many flushed responses remain
   bit m_owed, m_held;
   logic [31:0] m_buf;
   int m_cnt;

   mem_stage_handoff #(.DATA_W(32), .DISC_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .line1_now_valid_i(l1), .line2_now_valid_i(l2), .line1_mem_wait_i(mw),
      .excep_flush_i(flush), .next_allowin_i(nxt),
      .data_sram_data_ok_i(ok), .data_sram_rdata_i(rdata),
      .now_allowin_o(allowin), .line1_now_to_next_valid_o(v1), .line2_now_to_next_valid_o(v2),
      .load_data_o(load), .discard_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      bit need, acc;
      int nc;
      need = l1 && mw;
      acc = ok && m_cnt == 0;
      if (rst_n) begin
         m_owed = 0; m_held = 0; m_buf = 0; m_cnt = 0;
      end else begin
         nc = m_cnt;
         if (ok && m_cnt > 0) nc = nc - 1;
         if (flush && !acc && !m_held && (m_owed || need)) nc = nc + 1;
         m_cnt = nc > 3 ? 3 : nc;
         if (flush) begin
            m_owed = 0; m_held = 0;
         end else if (m_held) begin
            if (nxt) m_held = 0;
         end else if ((m_owed || need) && acc) begin
            m_owed = 0;
            if (!nxt) begin m_held = 1; m_buf = rdata; end
         end else if (need) m_owed = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic set_in(bit a, bit b, bit w, bit f, bit n, bit o, logic [31:0] d);
      l1 = a; l2 = b; mw = w; flush = f; nxt = n; ok = o; rdata = d;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1;
      set_in(0, 0, 0, 0, 1, 0, 0);
      tick(); tick();
      rst_n = 0;
   endtask

   task automatic test_reset();
      do_reset();
      set_in(1, 1, 0, 0, 1, 0, 32'h5);
      tests++; if (allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin got %b exp 1", allowin); end
      tests++; if ({v1, v2} !== 2'b11) begin fails++; $display("FAIL reset_valids got %b exp 11", {v1, v2}); end
      tests++; if (cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
      tests++; if (load !== 32'h5) begin fails++; $display("FAIL reset_load got %h exp 5", load); end
      set_in(0, 0, 1, 0, 0, 0, 0);
      tests++; if (allowin !== 1'b1) begin fails++; $display("FAIL reset_empty_allowin got %b exp 1", allowin); end
   endtask

   task automatic test_load_latency();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 1, 0, 1, 0, 32'h0);
         tests++; if ({allowin, v1, v2} !== 3'b000) begin fails++; $display("FAIL lat_wait%0d got %b exp 000", i, {allowin, v1, v2}); end
         tick();
      end
      set_in(1, 1, 1, 0, 1, 1, 32'hDEADBEEF);
      tests++; if ({allowin, v1, v2} !== 3'b111) begin fails++; $display("FAIL lat_ok got %b exp 111", {allowin, v1, v2}); end
      tests++; if (load !== 32'hDEADBEEF) begin fails++; $display("FAIL lat_load got %h exp deadbeef", load); end
      tick();
      set_in(1, 1, 1, 0, 1, 0, 32'h77);
      tests++; if (allowin !== 1'b0 || load !== 32'h77) begin fails++; $display("FAIL lat_idle got allowin %b load %h exp 0 77", allowin, load); end
   endtask

   task automatic test_wb_stall();
      do_reset();
      for (int i = 0; i < 3; i++) begin set_in(1, 1, 1, 0, 1, 0, 0); tick(); end
      set_in(1, 1, 1, 0, 0, 1, 32'hDEADBEEF);
      tests++; if ({allowin, v1, v2} !== 3'b011) begin fails++; $display("FAIL stall_ok got %b exp 011", {allowin, v1, v2}); end
      tick();
      for (int i = 0; i < 2; i++) begin
         set_in(1, 1, 1, 0, 0, 0, 32'h0);
         tests++; if (load !== 32'hDEADBEEF) begin fails++; $display("FAIL stall_hold%0d got %h exp deadbeef", i, load); end
         tests++; if ({allowin, v1, v2} !== 3'b011) begin fails++; $display("FAIL stall_flags%0d got %b exp 011", i, {allowin, v1, v2}); end
         if (i == 0) tick();
      end
      set_in(1, 1, 1, 0, 1, 0, 32'h0);
      tests++; if (allowin !== 1'b1 || load !== 32'hDEADBEEF) begin fails++; $display("FAIL stall_release got %b %h exp 1 deadbeef", allowin, load); end
      tick();
      set_in(0, 0, 0, 0, 1, 0, 32'h0);
      tests++; if (load !== 32'h0) begin fails++; $display("FAIL stall_after got %h exp 0", load); end
   endtask

   task automatic test_flush_discard();
      do_reset();
      set_in(1, 0, 1, 0, 1, 0, 0); tick();
      set_in(1, 0, 1, 1, 1, 0, 0);
      tests++; if ({v1, v2} !== 2'b00) begin fails++; $display("FAIL fd_flush_valids got %b exp 00", {v1, v2}); end
      tick();
      set_in(1, 0, 1, 0, 1, 1, 32'h1111);
      tests++; if (cnt !== 2'd1) begin fails++; $display("FAIL fd_cnt1 got %0d exp 1", cnt); end
      tests++; if ({allowin, v1} !== 2'b00) begin fails++; $display("FAIL fd_drop got %b exp 00", {allowin, v1}); end
      tick();
      set_in(1, 0, 1, 0, 1, 1, 32'h2222);
      tests++; if (cnt !== 2'd0) begin fails++; $display("FAIL fd_cnt0 got %0d exp 0", cnt); end
      tests++; if ({allowin, v1} !== 2'b11 || load !== 32'h2222) begin fails++; $display("FAIL fd_accept got %b %h exp 11 2222", {allowin, v1}, load); end
      tick();
   endtask

   task automatic test_flush_accept();
      do_reset();
      set_in(1, 1, 1, 0, 1, 0, 0); tick();
      set_in(1, 1, 1, 1, 1, 1, 32'h3333);
      tests++; if ({v1, v2} !== 2'b00) begin fails++; $display("FAIL fa_valids got %b exp 00", {v1, v2}); end
      tick();
      set_in(0, 0, 0, 0, 1, 0, 0);
      tests++; if (cnt !== 2'd0) begin fails++; $display("FAIL fa_cnt got %0d exp 0", cnt); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_c;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 1, 0, 1, 0, 0); tick();
         set_in(1, 0, 1, 1, 1, 0, 0); tick();
         exp_c = (i < 3) ? 2'(i + 1) : 2'd3;
         tests++; if (cnt !== exp_c) begin fails++; $display("FAIL sat_cnt%0d got %0d exp %0d", i, cnt, exp_c); end
      end
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 1, 0, 1, 1, 32'hAAAA);
         tests++; if (allowin !== 1'b0) begin fails++; $display("FAIL sat_block%0d got %b exp 0", i, allowin); end
         tick();
         exp_c = 2'(2 - i);
         tests++; if (cnt !== exp_c) begin fails++; $display("FAIL sat_drain%0d got %0d exp %0d", i, cnt, exp_c); end
      end
      set_in(1, 0, 1, 0, 1, 1, 32'hBBBB);
      tests++; if (allowin !== 1'b1 || load !== 32'hBBBB) begin fails++; $display("FAIL sat_accept got %b %h exp 1 bbbb", allowin, load); end
      tick();
   endtask

   task automatic test_random();
      bit need, rg;
      logic [31:0] e_load;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 99) < 2);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom);
         need = l1 && mw;
         rg = !need || m_held || (ok && m_cnt == 0);
         e_load = m_held ? m_buf : rdata;
         tests++; if (allowin !== (!(l1 || l2) || (rg && nxt))) begin fails++; $display("FAIL rnd_allowin@%0d got %b", i, allowin); end
         tests++; if (v1 !== (l1 && rg && !flush) || v2 !== (l2 && rg && !flush)) begin fails++; $display("FAIL rnd_valids@%0d got %b%b", i, v1, v2); end
         tests++; if (load !== e_load) begin fails++; $display("FAIL rnd_load@%0d got %h exp %h", i, load, e_load); end
         tests++; if (cnt !== 2'(m_cnt)) begin fails++; $display("FAIL rnd_cnt@%0d got %0d exp %0d", i, cnt, m_cnt); end
         tick();
      end
      rst_n = 0;
   endtask

   initial begin
      test_reset();
      test_load_latency();
      test_wb_stall();
      test_flush_discard();
      test_flush_accept();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_stage_handoff.md
Name: mem_stage_handoff

Overview:
- MEM-stage control for the dual-issue pipeline; it is the sending end of the MEM→WB valid/allowin handshake.
- Takes the two lane valids from the EXE→MEM register and holds the MEM bundle until the line-1 data-SRAM response has arrived.
- Produces per-lane to-WB valids and the MEM-stage allowin.
- Buffers load data when WB stalls, and discards stale responses of requests that were flushed.

Parameters:
- DATA_W, 32, data-SRAM read data width
- DISC_W, 2, width of the stale-response discard counter (max 2^DISC_W-1 outstanding flushed requests)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-high (asserted at 1'b1, i.e. `RstEnable`)
- line1_now_valid_i  in  1  lane-1 instruction present in MEM
- line2_now_valid_i  in  1  lane-2 instruction present in MEM
- line1_mem_wait_i  in  1  lane-1 instruction issued a data-SRAM request in EXE and its response is owed
- excep_flush_i  in  1  exception/ertn flush
- next_allowin_i  in  1  WB can accept this cycle
- data_sram_data_ok_i  in  1  data-SRAM response strobe
- data_sram_rdata_i  in  DATA_W  response data
- now_allowin_o  out  1  MEM can accept a new bundle
- line1_now_to_next_valid_o  out  1  lane-1 valid toward WB register
- line2_now_to_next_valid_o  out  1  lane-2 valid toward WB register
- load_data_o  out  DATA_W  load result for the lane-1 instruction
- discard_cnt_o  out  DISC_W  current stale-response count (debug/verification)

Behaviour:
- States: IDLE (nothing owed or not yet waiting), WAIT (lane-1 response owed), DONE (response captured, WB stalled).
- bundle_valid = line1_now_valid_i | line2_now_valid_i.
- need = line1_now_valid_i & line1_mem_wait_i.
- accept = data_sram_data_ok_i & (discard_cnt == 0).
- ready_go = !need | (state==DONE) | accept. This is combinational, so latency is zero when data_ok arrives in the same cycle.
- now_allowin_o = !bundle_valid | (ready_go & next_allowin_i).
- lineK_now_to_next_valid_o = lineK_now_valid_i & ready_go & !excep_flush_i.
- load_data_o = (state==DONE) ? data_buf : data_sram_rdata_i.
- Transitions (apply only when excep_flush_i is 0):
  - IDLE → WAIT: need & !accept.
  - IDLE/WAIT → DONE: need & accept & !next_allowin_i; data_buf <= rdata.
  - WAIT → IDLE: accept & next_allowin_i.
  - DONE → IDLE: next_allowin_i.
  - Otherwise hold.
- data_ok while discard_cnt>0:
  - Response dropped, discard_cnt decrements.
  - Does not satisfy ready_go.
- Flush, takes priority over all transitions above:
  - WAIT and no accept this cycle → discard_cnt+1, state IDLE.
  - IDLE with need and no accept → same (+1, IDLE).
  - WAIT/IDLE with accept → response consumed, no increment, state IDLE.
  - DONE → IDLE, no increment.
  - Flush coinciding with a drop → net count unchanged.
- discard_cnt saturates at 2^DISC_W-1, with no wrap.
- Reset values:
  - state IDLE, data_buf 0, discard_cnt 0.
  - Outputs follow combinationally: now_allowin_o=1 when lanes are invalid; to-next valids follow their inputs.
  - Reset mid-WAIT clears discard tracking; the memory side is reset together.
- Lane 2 never waits on memory; its valid rides with the lane-1 ready_go so the bundle advances atomically.

Test Plan:
1. Reset; lanes valid=1/1, mem_wait=0, next_allowin=1 → allowin=1 and both to_next valids=1 in the same cycle; discard_cnt=0.
2. Lane-1 load, mem_wait=1; data_ok arrives after 3 cycles with rdata=0xDEADBEEF, next_allowin=1 → allowin=0 for cycles 1-3; on the data_ok cycle to_next valids=1/1, load_data_o=0xDEADBEEF; state returns to IDLE.
3. Same as scenario 2 but next_allowin=0 for 2 cycles after data_ok → state DONE and load_data_o holds 0xDEADBEEF while rdata changes to 0x0; released when next_allowin=1.
4. Flush in WAIT with no data_ok → discard_cnt=1. The next data_ok (rdata=0x1111) is dropped and discard_cnt returns to 0. A new load then accepts data_ok with rdata=0x2222 → load_data_o=0x2222.
5. Flush in the same cycle as an accepted data_ok → discard_cnt stays 0; to_next valids are 0 in that cycle.
6. Four consecutive flushed waits with no responses, DISC_W=2 → discard_cnt saturates at 3. Three data_ok pulses then drain the count to 0 while allowin stays blocked for any waiting load.
